// File: rtl/fpc_pkg.sv
// Shared constants and types for the frequent-pattern line compressor.
package fpc_pkg;

  localparam int FPC_WORDS  = 8;
  localparam int FPC_WORD_W = 32;

  localparam logic [2:0] FPC_ZERO = 3'b000;
  localparam logic [2:0] FPC_SE4  = 3'b001;
  localparam logic [2:0] FPC_SE8  = 3'b010;
  localparam logic [2:0] FPC_SE16 = 3'b011;
  localparam logic [2:0] FPC_HALF = 3'b100;
  localparam logic [2:0] FPC_REP  = 3'b101;
  localparam logic [2:0] FPC_RSVD = 3'b110;
  localparam logic [2:0] FPC_RAW  = 3'b111;

  localparam logic [5:0] FPC_ZERO_W = 6'd0;
  localparam logic [5:0] FPC_SE4_W  = 6'd4;
  localparam logic [5:0] FPC_SE8_W  = 6'd8;
  localparam logic [5:0] FPC_SE16_W = 6'd16;
  localparam logic [5:0] FPC_HALF_W = 6'd16;
  localparam logic [5:0] FPC_REP_W  = 6'd8;
  localparam logic [5:0] FPC_RAW_W  = 6'd32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COMP = 2'd1,
    ST_DONE = 2'd2
  } fpc_state_e;

  function automatic logic [FPC_WORD_W-1:0] fpc_width_mask(input logic [5:0] w);
    if (w >= 6'd32) begin
      return {FPC_WORD_W{1'b1}};
    end else begin
      return (32'd1 << w) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/fpc_word_classify.sv
// Combinational classifier: one 32-bit word to prefix code, right-aligned payload and width.
module fpc_word_classify
  import fpc_pkg::*;
(
  input  logic [FPC_WORD_W-1:0] word,
  output logic [2:0]            prefix,
  output logic [FPC_WORD_W-1:0] payload,
  output logic [5:0]            width
);

  logic se4_s;
  logic se8_s;
  logic se16_s;
  logic rep_s;
  logic [FPC_WORD_W-1:0] raw_s;

  assign se4_s  = (word[31:3]  == {29{word[3]}});
  assign se8_s  = (word[31:7]  == {25{word[7]}});
  assign se16_s = (word[31:15] == {17{word[15]}});
  assign rep_s  = (word[31:24] == word[23:16]) && (word[23:16] == word[15:8]) &&
                  (word[15:8] == word[7:0]);

  // Priority classification: lowest matching code wins
  always_comb begin
    prefix = FPC_RAW;
    width  = FPC_RAW_W;
    raw_s  = word;
    if (word == 32'd0) begin
      prefix = FPC_ZERO;
      width  = FPC_ZERO_W;
    end else if (se4_s) begin
      prefix = FPC_SE4;
      width  = FPC_SE4_W;
    end else if (se8_s) begin
      prefix = FPC_SE8;
      width  = FPC_SE8_W;
    end else if (se16_s) begin
      prefix = FPC_SE16;
      width  = FPC_SE16_W;
    end else if (word[15:0] == 16'd0) begin
      prefix = FPC_HALF;
      width  = FPC_HALF_W;
      raw_s  = {16'd0, word[31:16]};
    end else if (rep_s) begin
      prefix = FPC_REP;
      width  = FPC_REP_W;
    end else begin
      prefix = FPC_RAW;
      width  = FPC_RAW_W;
    end
    payload = raw_s & fpc_width_mask(width);
  end

endmodule

// File: rtl/fpc_line_compressor.sv
// Frequent-pattern compressor for one cache line per handshake, one word per cycle.
// Optional all-zero-line fast path enabled by defining FPC_ZERO_LINE_EN.
module fpc_line_compressor
  import fpc_pkg::*;
#(
  parameter int WORDS  = FPC_WORDS,
  parameter int WORD_W = FPC_WORD_W,
  parameter int OUT_W  = WORDS * (WORD_W + 3)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORDS*WORD_W-1:0]   in_line,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic [8:0]                out_len,
  output logic                      out_zero
);

  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  fpc_state_e              state_r;
  logic                    in_ready_r;
  logic                    out_valid_r;
  logic [WORDS*WORD_W-1:0] line_r;
  logic [OUT_W-1:0]        buf_r;
  logic [8:0]              ofs_r;
  logic [IDX_W-1:0]        idx_r;
  logic [2:0]              prefix_s;
  logic [WORD_W-1:0]       payload_s;
  logic [5:0]              width_s;
  logic [OUT_W-1:0]        ins_s;
`ifdef FPC_ZERO_LINE_EN
  logic                    zero_r;
`endif

  // The captured line shifts left each COMP cycle, so the current word is always on top
  fpc_word_classify u_classify (
    .word    (line_r[WORDS*WORD_W-1 -: WORD_W]),
    .prefix  (prefix_s),
    .payload (payload_s),
    .width   (width_s)
  );

  assign ins_s = {{(OUT_W-WORD_W-3){1'b0}}, payload_s, prefix_s} << ofs_r;

  // Control FSM, counters and bitstream buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      line_r      <= '0;
      buf_r       <= '0;
      ofs_r       <= 9'd0;
      idx_r       <= '0;
`ifdef FPC_ZERO_LINE_EN
      zero_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            line_r     <= in_line;
            buf_r      <= '0;
            ofs_r      <= 9'd0;
            idx_r      <= '0;
            in_ready_r <= 1'b0;
`ifdef FPC_ZERO_LINE_EN
            if (in_line == '0) begin
              zero_r      <= 1'b1;
              out_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end else begin
              zero_r  <= 1'b0;
              state_r <= ST_COMP;
            end
`else
            state_r <= ST_COMP;
`endif
          end
        end
        ST_COMP: begin
          buf_r  <= buf_r | ins_s;
          ofs_r  <= ofs_r + 9'(width_s) + 9'd3;
          line_r <= line_r << WORD_W;
          idx_r  <= idx_r + IDX_W'(1);
          if (idx_r == IDX_LAST) begin
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = buf_r;
  assign out_len   = ofs_r;
`ifdef FPC_ZERO_LINE_EN
  assign out_zero  = zero_r;
`else
  assign out_zero  = 1'b0;
`endif

endmodule

// File: doc/fpc_line_compressor.md
# fpc_line_compressor

Frequent-pattern compressor for 256-bit uncompressed cache lines, sitting directly downstream of the trace-to-cache-line packer. It accepts one line per valid/ready handshake and classifies its eight 32-bit words one per cycle against a fixed pattern table. It packs a 3-bit prefix plus a variable-width payload per word into a compressed bitstream, then presents the stream and its bit length on a valid/ready output.

## Interface
- `WORDS`, default 8: words per line.
- `WORD_W`, default 32: bits per word.
- `OUT_W`, default `WORDS*(WORD_W+3)` = 280: compressed buffer width.
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: `in_line` valid.
- `in_ready` out 1: block can accept a line.
- `in_line` in 256: uncompressed line; word 0 = `[255:224]`, word 7 = `[31:0]`.
- `out_valid` out 1: compressed result valid.
- `out_ready` in 1: consumer accepts result.
- `out_data` out `OUT_W`: compressed stream, LSB-first; bits at and above `out_len` are 0.
- `out_len` out 9: compressed length in bits, range 0..280.
- `out_zero` out 1: line was all-zero (fast path).

## Operation
- FSM states: IDLE, COMP, DONE.
  - IDLE: `in_ready`=1. On `in_valid`: capture line, clear offset and buffer, set word index to 0, go to COMP.
  - COMP: process word[idx], then idx+1. After idx=7, go to DONE.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE.
- Classification priority: the lowest code wins when several patterns match.
  - 000 zero word: 0-bit payload.
  - 001 sign-extended 4-bit: 4-bit payload.
  - 010 sign-extended 8-bit: 8-bit payload.
  - 011 sign-extended 16-bit: 16-bit payload.
  - 100 low half zero: 16-bit payload = upper half.
  - 101 four repeated bytes: 8-bit payload.
  - 111 uncompressed: 32-bit payload.
  - 110 is reserved and never emitted.
- Append rule at offset `ofs`:
  - prefix goes to `[ofs+2:ofs]`.
  - payload of n bits goes to `[ofs+3+n-1:ofs+3]`.
  - then `ofs += 3+n`.
- `out_len` = final `ofs`. No saturation is needed: the maximum is exactly 280.
- `in_line` is sampled only on the input handshake. Input changes afterwards have no effect.
- `out_data`, `out_len` and `out_zero` are held stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values: `in_ready`=1 (state IDLE), `out_valid`=0, `out_data`=0, `out_len`=0, `out_zero`=0, internal `ofs` and `idx` = 0.
- Input handshake in cycle T:
  - words are processed in cycles T+1..T+8;
  - `out_valid` rises at T+9.
- Output handshake in cycle U: `out_valid`=0 and `in_ready`=1 at U+1.
- Minimum line period is 10 cycles. There is no overlap of input and output handshakes.
- `in_ready` and `out_valid` are never high together.
- `rst` in any state, including mid-COMP or DONE with backpressure:
  - the next cycle shows reset values;
  - the partial or pending line is discarded.

## Configuration
- Macro: `FPC_ZERO_LINE_EN`.
- Defined:
  - an all-zero `in_line` accepted at T bypasses COMP;
  - DONE is reached at T+1 with `out_len`=0, `out_data`=0, `out_zero`=1.
  - Non-zero lines behave as normal with `out_zero`=0.
- Undefined:
  - no fast path; a zero line takes 8 COMP cycles, giving `out_len`=24 and `out_data`=0;
  - `out_zero` is tied to 0.

## Structure
- Shared package `fpc_pkg` holds:
  - prefix code localparams (`FPC_ZERO` .. `FPC_RAW`);
  - per-code payload widths;
  - the FSM state typedef;
  - the `WORDS`/`WORD_W` defaults.
- One sub-module, `fpc_word_classify`: combinational, 32-bit word in, 3-bit prefix, 32-bit payload (right-aligned) and 6-bit payload width out.
- The top level owns the FSM, the index and offset counters, and the shift-insert into the 280-bit buffer.

## Test plan
- Eight words 0x00000001 (no fast path): each word is 7-bit chunk 0x09, `out_len`=56, `out_valid` at T+9.
- Mixed line:
  - word0 0xFFFFFF80 gives 010, payload 0x80;
  - word1 0xABCD0000 gives 100, payload 0xABCD;
  - word2 0x7A7A7A7A gives 101, payload 0x7A;
  - word3 0x00001234 gives 011, payload 0x1234;
  - words 4–7 are zero;
  - result `out_len`=72 and bit-exact `out_data`.
- All words 0x12345678 gives `out_len`=280, each 35-bit chunk = 0x12345678<<3 | 7.
- All-zero line:
  - with `FPC_ZERO_LINE_EN`: `out_valid` at T+1, `out_len`=0, `out_zero`=1;
  - without it: `out_valid` at T+9, `out_len`=24, `out_zero`=0.
- Backpressure: `out_ready` low 5 cycles in DONE keeps outputs stable and `in_ready`=0. Accept at U gives `in_ready`=1 at U+1.
- `rst` pulsed at T+4 of COMP: at T+5 `in_ready`=1 and `out_valid`=0. The next line compresses correctly.
